rle_decoder: RTL and testbench

Run-length decoder for the receive/decompression side of the DCT+RLE EEG path. It accepts (run, level, end-of-block) tokens and expands them back into a stream of signed DCT coefficients, Z0..Z7 per block, with a valid/ready handshake on both sides. Each block is N coefficients. Its output feeds the inverse-DCT stage, and its coefficient width matches the 18-bit bit-serial DCT coefficient outputs.

---
 rtl/rle_decoder.sv | 118 +++++++++++
 tb/tb_rle_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (run, level, eob) tokens into a block of N
// signed coefficients with valid/ready handshakes on input and output.
module rle_decoder #(
  parameter int DW = 18,
  parameter int N  = 8,
  parameter int RW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RW-1:0]        in_run,
  input  logic signed [DW-1:0] in_level,
  input  logic                 in_eob,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_coef,
  output logic [RW-1:0]        out_idx,
  output logic                 out_last,
  output logic                 err
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ZEROS  = 2'd1,
    LEVEL  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);
  localparam logic [RW:0]   LAST_EXT = (RW + 1)'(N - 1);

  state_t                 state_r;
  logic [RW-1:0]          idx_r;
  logic [RW-1:0]          run_q_r;
  logic signed [DW-1:0]   level_q_r;

  logic                   accept_s;
  logic                   beat_s;
  logic [RW:0]            span_s;

  // Handshake decode and run-overflow span; in_ready depends on state only.
  always_comb begin
    in_ready = (state_r == ACCEPT);
    accept_s = in_valid && (state_r == ACCEPT);
    beat_s   = (state_r != ACCEPT) && (!out_valid || out_ready);
    span_s   = {1'b0, idx_r} + {1'b0, in_run};
  end

  // Token FSM, index counter and registered output beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ACCEPT;
      idx_r     <= '0;
      run_q_r   <= '0;
      level_q_r <= '0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (beat_s) begin
        out_valid <= 1'b1;
        out_idx   <= idx_r;
        out_last  <= (idx_r == LAST_IDX);
        idx_r     <= idx_r + RW'(1'b1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_r)
        ACCEPT: begin
          if (accept_s) begin
            if (in_eob) begin
              state_r <= FLUSH;
            end else if (span_s > LAST_EXT) begin
              // Run would cross the block boundary: drop the level, pad out.
              err     <= 1'b1;
              state_r <= FLUSH;
            end else begin
              run_q_r   <= in_run;
              level_q_r <= in_level;
              state_r   <= (in_run != '0) ? ZEROS : LEVEL;
            end
          end
        end
        ZEROS: begin
          if (beat_s) begin
            out_coef <= '0;
            run_q_r  <= run_q_r - RW'(1'b1);
            if (run_q_r == RW'(1'b1)) begin
              state_r <= LEVEL;
            end
          end
        end
        LEVEL: begin
          if (beat_s) begin
            out_coef <= level_q_r;
            state_r  <= ACCEPT;
          end
        end
        FLUSH: begin
          if (beat_s) begin
            out_coef <= '0;
            if (idx_r == LAST_IDX) begin
              state_r <= ACCEPT;
            end
          end
        end
        default: begin
          state_r <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Scoreboard bench for rle_decoder: directed tokens push hand-computed beats,
// a negedge monitor pops and compares every transferred output beat.
module tb_rle_decoder;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_run;
  logic signed [17:0] in_level;
  logic               in_eob;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_coef;
  logic [2:0]         out_idx;
  logic               out_last;
  logic               err;

  typedef struct packed {
    logic [17:0] coef;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cycles[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    cycle     = 0;
  int    beat_cnt  = 0;
  bit    timing_on = 1'b0;

  rle_decoder #(.DW(18), .N(8), .RW(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_run(in_run), .in_level(in_level), .in_eob(in_eob),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coef(out_coef), .out_idx(out_idx), .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic signed [17:0] c, input logic [2:0] i, input logic l);
    beat_t b;
    b.coef = c;
    b.idx  = i;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: a beat transfers at the next rising edge when valid && ready now.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      beat_t b;
      beat_cnt++;
      if (timing_on) beat_cycles.push_back(cycle);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_idx", {29'd0, out_idx}, 32'hFFFF_FFFF);
      end else begin
        b = exp_q.pop_front();
        chk("beat_coef", {14'd0, out_coef}, {14'd0, b.coef});
        chk("beat_idx",  {29'd0, out_idx},  {29'd0, b.idx});
        chk("beat_last", {31'd0, out_last}, {31'd0, b.last});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [2:0] r, input logic signed [17:0] l, input logic e);
    int n = 0;
    in_valid = 1'b1;
    in_run   = r;
    in_level = l;
    in_eob   = e;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_eob   = 1'b1;
    in_run   = 3'd5;
    in_level = 18'sh15555;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    int bc0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_run    = 3'd0;
    in_level  = 18'sd0;
    in_eob    = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_coef",  {14'd0, out_coef},  32'd0);
    chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: eight (run=0, level=5) tokens, one beat every two cycles.
    timing_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_beat(18'sd5, 3'(i), (i == 7));
      send(3'd0, 18'sd5, 1'b0);
    end
    drain("t1_drain");
    timing_on = 1'b0;
    chk("t1_beat_count", beat_cycles.size(), 32'd8);
    for (int i = 1; i < beat_cycles.size(); i++)
      chk("t1_beat_spacing", beat_cycles[i] - beat_cycles[i-1], 32'd2);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 2: (run=2, level=-3) then EOB.
    for (int i = 0; i < 8; i++) expect_beat((i == 2) ? -18'sd3 : 18'sd0, 3'(i), (i == 7));
    send(3'd2, -18'sd3, 1'b0);
    chk("t2_in_ready_after_token", {31'd0, in_ready}, 32'd0);
    send(3'd7, 18'sd99, 1'b1);
    chk("t2_in_ready_in_flush", {31'd0, in_ready}, 32'd0);
    drain("t2_drain");
    chk("t2_in_ready_after_block", {31'd0, in_ready}, 32'd1);

    // 3: EOB at idx 0 gives a full block of zeros.
    for (int i = 0; i < 8; i++) expect_beat(18'sd0, 3'(i), (i == 7));
    send(3'd0, 18'sd0, 1'b1);
    drain("t3_drain");
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);

    // 4: overflow at idx 6 with run=3.
    for (int i = 0; i < 6; i++) begin
      expect_beat(18'(10 + i), 3'(i), 1'b0);
      send(3'd0, 18'(10 + i), 1'b0);
    end
    chk("t4_err_before", {31'd0, err}, 32'd0);
    expect_beat(18'sd0, 3'd6, 1'b0);
    expect_beat(18'sd0, 3'd7, 1'b1);
    send(3'd3, 18'sd9, 1'b0);
    chk("t4_err_set", {31'd0, err}, 32'd1);
    expect_beat(18'sd1, 3'd0, 1'b0);
    send(3'd0, 18'sd1, 1'b0);
    for (int i = 1; i < 8; i++) expect_beat(18'sd0, 3'(i), (i == 7));
    send(3'd0, 18'sd0, 1'b1);
    drain("t4_drain");
    chk("t4_err_sticky", {31'd0, err}, 32'd1);

    // 5: (run=4, level=7) with a 3-cycle stall on the idx 1 beat.
    bc0 = beat_cnt;
    for (int i = 0; i < 5; i++) expect_beat((i == 4) ? 18'sd7 : 18'sd0, 3'(i), 1'b0);
    out_ready = 1'b0;
    send(3'd4, 18'sd7, 1'b0);
    @(posedge clk); #1;
    chk("t5_first_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_stall_idx",   {29'd0, out_idx},   32'd1);
      chk("t5_stall_coef",  {14'd0, out_coef},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("t5_drain");
    chk("t5_beat_total", beat_cnt - bc0, 32'd5);
    for (int i = 5; i < 8; i++) expect_beat(18'sd0, 3'(i), (i == 7));
    send(3'd0, 18'sd0, 1'b1);
    drain("t5_close_drain");

    // 6: asynchronous reset while the idx 3 flush beat is presented.
    for (int i = 0; i < 3; i++) expect_beat(18'sd0, 3'(i), 1'b0);
    send(3'd0, 18'sd0, 1'b1);
    begin
      int n = 0;
      while (!(out_valid && out_idx == 3'd3) && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("t6_reach_idx3", {31'd0, (out_valid && out_idx == 3'd3)}, 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("t6_pending_beats", exp_q.size(), 32'd0);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_out_idx",   {29'd0, out_idx},   32'd0);
    chk("t6_out_last",  {31'd0, out_last},  32'd0);
    chk("t6_err",       {31'd0, err},       32'd0);
    chk("t6_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    expect_beat(18'sd0, 3'd0, 1'b0);
    expect_beat(18'sd2, 3'd1, 1'b0);
    send(3'd1, 18'sd2, 1'b0);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
